// File: rtl/regfile_debug_walker.sv
// Debug-side walker for the RV32I register file: dumps all 32 registers as a
// ready/valid stream, fills x01..x31 with one value, or writes a single register.
module regfile_debug_walker (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        rf_wr_ena,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_last,
    output logic [2:0]  dbg_state
);

    // Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready;
    // a dump beat transfers on a cycle where dump_valid && dump_ready. Beat
    // contents are held stable while dump_valid is high and dump_ready is low.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DUMP_READ = 3'd1,
        S_DUMP_HOLD = 3'd2,
        S_FILL      = 3'd3,
        S_WRITE     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_ptr;
    logic [4:0]  w_ptr_next;
    logic [31:0] r_data_q;
    logic [4:0]  r_addr_q;
    logic        r_dump_valid;
    logic        r_dump_last;
    logic [4:0]  r_dump_addr;
    logic [31:0] r_dump_data;
    logic        w_accept;
    logic        w_wr_ena;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_accept     = 1'b0;
        w_wr_ena     = 1'b0;
        w_wr_addr    = 5'd0;
        w_wr_data    = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    case (cmd_op)
                        2'b00: begin
                            w_ptr_next   = 5'd0;
                            w_state_next = S_DUMP_READ;
                        end
                        2'b01: begin
                            w_ptr_next   = 5'd1;
                            w_state_next = S_FILL;
                        end
                        2'b10:   w_state_next = S_WRITE;
                        default: w_state_next = S_DONE;
                    endcase
                end
            end
            S_DUMP_READ: w_state_next = S_DUMP_HOLD;
            S_DUMP_HOLD: begin
                if (dump_ready) begin
                    if (r_ptr == 5'd31) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_ptr_next   = r_ptr + 5'd1;
                        w_state_next = S_DUMP_READ;
                    end
                end
            end
            S_FILL: begin
                w_wr_ena  = 1'b1;
                w_wr_addr = r_ptr;
                w_wr_data = r_data_q;
                if (r_ptr == 5'd31) begin
                    w_state_next = S_DONE;
                end else begin
                    w_ptr_next = r_ptr + 5'd1;
                end
            end
            S_WRITE: begin
                // x00 is hardwired; the write is dropped but the command still completes.
                if (r_addr_q != 5'd0) begin
                    w_wr_ena  = 1'b1;
                    w_wr_addr = r_addr_q;
                    w_wr_data = r_data_q;
                end
                w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= 5'd0;
            r_data_q     <= 32'd0;
            r_addr_q     <= 5'd0;
            r_dump_valid <= 1'b0;
            r_dump_last  <= 1'b0;
            r_dump_addr  <= 5'd0;
            r_dump_data  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            if (w_accept) begin
                r_data_q <= cmd_data;
                r_addr_q <= cmd_addr;
            end
            if (r_state == S_DUMP_READ) begin
                r_dump_valid <= 1'b1;
                r_dump_data  <= rf_rd_data;
                r_dump_addr  <= r_ptr;
                r_dump_last  <= (r_ptr == 5'd31);
            end else if (r_state == S_DUMP_HOLD && dump_ready) begin
                r_dump_valid <= 1'b0;
                r_dump_last  <= 1'b0;
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign rf_rd_addr = r_ptr;
    assign rf_wr_ena  = w_wr_ena;
    assign rf_wr_addr = w_wr_addr;
    assign rf_wr_data = w_wr_data;
    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;
    assign dump_last  = r_dump_last;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_regfile_debug_walker.sv
// Bench for regfile_debug_walker: behavioural register file, array model of the
// architectural registers, and an expected-beat queue for dumps.
module tb_regfile_debug_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        busy;
    logic        done;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        rf_wr_ena;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_last;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] rf_mem  [32];
    logic [31:0] seed_val[32];
    logic [31:0] exp_rf  [32];
    logic        rf_seed;
    logic [37:0] exp_q[$];

    regfile_debug_walker dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .busy(busy), .done(done),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_ena(rf_wr_ena), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_last(dump_last), .dbg_state(dbg_state)
    );

    // clock / reset-independent register file (no functional reset, x00 reads 0)
    always #5 clk = ~clk;

    assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'd0 : rf_mem[rf_rd_addr];

    always @(posedge clk) begin
        if (rf_seed) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= seed_val[i];
        end else if (rf_wr_ena) begin
            rf_mem[rf_wr_addr] <= rf_wr_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_wr"},    64'({rf_wr_ena, rf_wr_addr, rf_wr_data}), 64'd0);
        check({tag, "_dump"},  64'({dump_valid, dump_last, dump_addr, dump_data}), 64'd0);
        check({tag, "_ptr"},   64'(rf_rd_addr), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        check("cmd_ready_before", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
    endtask

    task automatic run_write(input logic [4:0] addr, input logic [31:0] data);
        issue(2'b10, addr, data);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wr_ena_k1", 64'(rf_wr_ena), 64'(addr != 5'd0));
        if (addr != 5'd0) check("wr_addr_data_k1", 64'({rf_wr_addr, rf_wr_data}), 64'({addr, data}));
        check("wr_busy_k1", 64'({busy, cmd_ready, done}), 64'b100);
        @(negedge clk);
        check("wr_done_k2", 64'({done, rf_wr_ena}), 64'b10);
        @(negedge clk);
        check("wr_ready_k3", 64'({cmd_ready, done}), 64'b10);
        if (addr != 5'd0) exp_rf[addr] = data;
    endtask

    task automatic run_noop();
        issue(2'b11, 5'($urandom), $urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("noop_done_k1", 64'({done, busy, cmd_ready, rf_wr_ena}), 64'b1100);
        @(negedge clk);
        check("noop_ready_k2", 64'({done, cmd_ready}), 64'b01);
    endtask

    // abort_at = 0 runs the fill to completion; otherwise reset is asserted in cycle k+abort_at
    task automatic run_fill(input logic [31:0] val, input int abort_at);
        issue(2'b01, 5'($urandom), val);
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            check("fill_wr", 64'({rf_wr_ena, rf_wr_addr, rf_wr_data, done}), 64'({1'b1, 5'(c), val, 1'b0}));
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                check_idle_outputs("abort_rst");
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("abort_no_done", 64'({done, rf_wr_ena}), 64'd0);
                end
                rst = 1'b0;
                @(negedge clk);
                check_idle_outputs("abort_release");
                for (int i = 1; i < abort_at; i++) exp_rf[i] = val;
                return;
            end
        end
        @(negedge clk);
        check("fill_done_k32", 64'({done, rf_wr_ena}), 64'b10);
        @(negedge clk);
        check("fill_ready_k33", 64'({cmd_ready, done}), 64'b10);
        for (int i = 1; i < 32; i++) exp_rf[i] = val;
    endtask

    task automatic run_dump(input bit rand_ready);
        int          c;
        int          beats;
        bit          stalled;
        logic [37:0] held;
        logic [37:0] e;
        exp_q.delete();
        for (int i = 0; i < 32; i++)
            exp_q.push_back({i == 31, 5'(i), (i == 0) ? 32'd0 : exp_rf[i]});
        issue(2'b00, 5'($urandom), $urandom);
        c = 0;
        beats = 0;
        stalled = 1'b0;
        held = '0;
        while (1) begin
            @(negedge clk);
            c++;
            // commands presented while busy must be ignored
            cmd_valid = (c > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_op    = 2'b10;
            cmd_addr  = 5'($urandom_range(1, 31));
            check("dump_no_wr", 64'(rf_wr_ena), 64'd0);
            if (stalled)
                check("dump_stable", 64'({dump_valid, dump_last, dump_addr, dump_data}), 64'({1'b1, held}));
            if (done) begin
                cmd_valid  = 1'b0;
                dump_ready = 1'b0;
                check("dump_beats", 64'(beats), 64'd32);
                if (!rand_ready) check("dump_done_cyc", 64'(c), 64'd65);
                break;
            end
            if (c > 1000) begin
                cmd_valid  = 1'b0;
                dump_ready = 1'b0;
                check("dump_timeout", 64'(c), 64'd0);
                break;
            end
            dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dump_valid) begin
                if (!stalled) begin
                    if (!rand_ready) check("dump_beat_cyc", 64'(c), 64'(2 + 2 * beats));
                    check("dump_no_extra", 64'(beats < 32), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("dump_beat", 64'({dump_last, dump_addr, dump_data}), 64'(e));
                    end
                    beats++;
                end
                held    = {dump_last, dump_addr, dump_data};
                stalled = !dump_ready;
            end else begin
                stalled = 1'b0;
            end
        end
        @(negedge clk);
        check("dump_after", 64'({done, cmd_ready}), 64'b01);
    endtask

    initial begin
        rst        = 1'b1;
        rf_seed    = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_addr   = 5'd0;
        cmd_data   = 32'd0;
        dump_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            seed_val[i] = (i == 0) ? 32'd0 : $urandom;
            exp_rf[i]   = seed_val[i];
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst     = 1'b0;
        rf_seed = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_dump(1'b0);

        run_fill(32'hA5A5A5A5, 0);
        run_dump(1'b0);

        run_write(5'd5, 32'hDEADBEEF);
        run_write(5'd0, 32'h12345678);
        run_dump(1'b1);

        for (int i = 1; i < 32; i++) run_write(5'(i), 32'(i) * 32'h01010101);
        run_dump(1'b0);

        repeat (6) run_write(5'($urandom_range(0, 31)), $urandom);
        run_noop();
        run_dump(1'b1);

        run_fill(32'h3C3C3C3C, 10);
        run_dump(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_debug_walker.md
# regfile_debug_walker

Debug-side counterpart to the core's register file. It drives the register file's write channel and one read channel from the outside, while the core is halted. It serves three commands: bulk-dump all 32 architectural registers as a ready/valid stream, bulk-fill x01..x31 with a value, and single-register write. Fill exists because the register instances carry no functional reset. The block sits between the debug/testbench command interface and the register file ports; external arbitration gives it the ports while `busy` is high.

## Interface
Parameters: none. All widths are fixed by the RV32I register file: 32 registers, 32-bit data, 5-bit address.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE; command accepted when `cmd_valid && cmd_ready`
- `cmd_op`  in  2  00 dump, 01 fill, 10 write single, 11 no-op (acknowledged, completes via DONE)
- `cmd_addr`  in  5  target register for write single
- `cmd_data`  in  32  write data (write single) or fill value (fill)
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse when a command completes
- `rf_rd_addr`  out  5  to register file read channel; equals internal pointer
- `rf_rd_data`  in  32  combinational read data for `rf_rd_addr`
- `rf_wr_ena`  out  1  register file write enable
- `rf_wr_addr`  out  5  register file write address
- `rf_wr_data`  out  32  register file write data
- `dump_valid`  out  1  dump beat valid
- `dump_ready`  in  1  sink accepts beat
- `dump_addr`  out  5  register index of current beat
- `dump_data`  out  32  register value of current beat
- `dump_last`  out  1  high with the beat for x31

## Operation
- Internal state:
  - 5-bit pointer `ptr`
  - 32-bit latched `data_q`
  - 5-bit latched `addr_q`
  - state register with states IDLE, DUMP_READ, DUMP_HOLD, FILL, WRITE, DONE
- Command accept in IDLE:
  - latch `cmd_data` into `data_q` and `cmd_addr` into `addr_q`
  - dump: `ptr`=0, next state DUMP_READ
  - fill: `ptr`=1, next state FILL
  - write single: next state WRITE
  - no-op: next state DONE
- DUMP_READ:
  - `rf_rd_addr`=`ptr`
  - register `rf_rd_data` into `dump_data` and `ptr` into `dump_addr`
  - set `dump_valid` and set `dump_last` = (`ptr`==31)
  - next state DUMP_HOLD
- DUMP_HOLD:
  - `dump_valid`, `dump_data`, `dump_addr` and `dump_last` stay stable until `dump_ready`
  - on handshake, clear `dump_valid`
  - if `ptr`==31, go to DONE; otherwise increment `ptr` and go to DUMP_READ
- Dump beat 0 always carries x00, whose value is 0 as returned by the register file.
- FILL:
  - `rf_wr_ena`=1, `rf_wr_addr`=`ptr`, `rf_wr_data`=`data_q`
  - if `ptr`==31, go to DONE; otherwise increment `ptr`
  - x00 is never addressed
- WRITE:
  - `rf_wr_addr`=`addr_q`, `rf_wr_data`=`data_q`
  - `rf_wr_ena` = (`addr_q` != 0), so a write to x00 is suppressed but still completes
  - next state DONE
- DONE: `done`=1 for this cycle only, next state IDLE.
- `rf_wr_ena`, `rf_wr_addr` and `rf_wr_data` are decoded from the state and pointer registers.
  - `rf_wr_ena` is 0 in every state other than FILL and WRITE.
  - `rf_wr_addr` and `rf_wr_data` read 0 when `rf_wr_ena` is 0.
- `cmd_valid` outside IDLE is ignored: it is not queued and not acknowledged.
- Reset values: state IDLE; `ptr` 0; `dump_valid` 0; `dump_last` 0; `dump_addr` 0; `dump_data` 0; `data_q` 0; `addr_q` 0; `done` 0; `rf_wr_ena` 0; `cmd_ready` 1; `busy` 0.
- Reset asserted mid-command aborts immediately:
  - no further writes are issued
  - a pending dump beat is dropped
  - `done` is not pulsed

## Timing
Cycle k is the command-accept cycle.
- Write single: WRITE at k+1 with `rf_wr_ena` high; `done` at k+2; `cmd_ready` at k+3.
- Fill: writes x01..x31 on k+1..k+31, one per cycle; `done` at k+32; `cmd_ready` at k+33.
- Dump with `dump_ready` held high:
  - beat n is valid at cycle k+2+2n
  - `dump_last` beat at k+64
  - `done` at k+65; `cmd_ready` at k+66
- Dump under backpressure: each cycle `dump_ready` is low extends the current beat by one cycle; beat contents do not change.
- Read sampling: `rf_rd_data` is sampled only in DUMP_READ. A write by another agent during DUMP_HOLD is reflected only in later beats.

## Test plan
- Write single: addr 5, data 0xDEADBEEF → `rf_wr_ena` high for exactly one cycle at k+1 with addr 5; `done` at k+2; a subsequent dump shows x05=0xDEADBEEF.
- Write single to x00: data 0x12345678 → `rf_wr_ena` stays 0; `done` still at k+2; dump beat 0 = 0.
- Fill 0xA5A5A5A5 → 31 consecutive writes, addr 1..31; `done` at k+32; dump returns 0 for x00 and 0xA5A5A5A5 for all others.
- Dump after writing x_i = i*0x01010101 → 32 beats with `dump_addr` 0..31 and matching data; `dump_last` only on beat 31; `done` at k+65.
- Dump with `dump_ready` toggled pseudo-randomly → same 32 beats in order; no beat is lost, duplicated, or changes while valid and not ready.
- Reset asserted during fill at k+10, then released → outputs take their reset values immediately; x10..x31 unwritten; no `done` pulse; `cmd_ready` is 1 after release.
